// File: rtl/clock_mode_ctrl.sv
// Mode/alarm sequencer for the HH:MM clock: turns button pulses into counter adjust strobes,
// owns the alarm registers and runs the ring/dismiss flow. All outputs are registered.
module clock_mode_ctrl #(
    parameter int RING_SECS = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_c,
    input  logic        btn_r,
    input  logic        btn_l,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        tick_1hz,
    input  logic [12:0] time_bcd,
    output logic        run_en,
    output logic        adj_min_stb,
    output logic        adj_hr_stb,
    output logic        adj_up,
    output logic [12:0] alarm_bcd,
    output logic        disp_alarm,
    output logic        alarm_armed,
    output logic        ringing,
    output logic [4:0]  led
);

    typedef enum logic [2:0] {
        CLOCK,
        ADJ_CMIN,
        ADJ_CHR,
        ADJ_AMIN,
        ADJ_AHR,
        RING
    } state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

    state_t      state, state_next;
    logic [7:0]  ring_cnt, ring_cnt_next;
    logic        match, match_q, ring_start;
    logic        act_c, act_r, act_l, act_u, act_d, any_btn;
    logic [12:0] alarm_next;
    logic        armed_next, min_stb_next, hr_stb_next, up_next;
    logic        blink_next, run_en_next, disp_next;
    logic [4:0]  led_next;

    // BCD minute step with wrap 59 <-> 00; hours field untouched
    function automatic logic [12:0] step_min(input logic [12:0] t, input logic up);
        logic [3:0] mu;
        logic [2:0] mt;
        mu = t[3:0];
        mt = t[6:4];
        if (up) begin
            if (mu == 4'd9) begin
                mu = 4'd0;
                mt = (mt == 3'd5) ? 3'd0 : mt + 3'd1;
            end else begin
                mu = mu + 4'd1;
            end
        end else begin
            if (mu == 4'd0) begin
                mu = 4'd9;
                mt = (mt == 3'd0) ? 3'd5 : mt - 3'd1;
            end else begin
                mu = mu - 4'd1;
            end
        end
        return {t[12:7], mt, mu};
    endfunction

    // BCD hour step with wrap 23 <-> 00; minutes field untouched
    function automatic logic [12:0] step_hr(input logic [12:0] t, input logic up);
        logic [3:0] hu;
        logic [1:0] ht;
        hu = t[10:7];
        ht = t[12:11];
        if (up) begin
            if (ht == 2'd2 && hu == 4'd3) begin
                ht = 2'd0;
                hu = 4'd0;
            end else if (hu == 4'd9) begin
                hu = 4'd0;
                ht = ht + 2'd1;
            end else begin
                hu = hu + 4'd1;
            end
        end else begin
            if (ht == 2'd0 && hu == 4'd0) begin
                ht = 2'd2;
                hu = 4'd3;
            end else if (hu == 4'd0) begin
                hu = 4'd9;
                ht = ht - 2'd1;
            end else begin
                hu = hu - 4'd1;
            end
        end
        return {ht, hu, t[6:0]};
    endfunction

    always_comb begin
        act_c      = btn_c;
        act_r      = btn_r & ~btn_c;
        act_l      = btn_l & ~btn_c & ~btn_r;
        act_u      = btn_u & ~btn_c & ~btn_r & ~btn_l;
        act_d      = btn_d & ~btn_c & ~btn_r & ~btn_l & ~btn_u;
        any_btn    = btn_c | btn_r | btn_l | btn_u | btn_d;
        match      = alarm_armed & (time_bcd == alarm_bcd);
        ring_start = match & ~match_q;
    end

    always_comb begin
        state_next    = state;
        ring_cnt_next = ring_cnt;
        blink_next    = led[4];
        alarm_next    = alarm_bcd;
        armed_next    = alarm_armed;
        min_stb_next  = 1'b0;
        hr_stb_next   = 1'b0;
        up_next       = 1'b0;
        run_en_next   = 1'b0;
        disp_next     = 1'b0;
        led_next      = 5'b00000;

        // A fresh match beats any button pressed in the same cycle
        case (state)
            CLOCK: begin
                if (ring_start) begin
                    state_next    = RING;
                    ring_cnt_next = 8'd0;
                    blink_next    = 1'b1;
                end else if (act_c) begin
                    state_next = ADJ_CMIN;
                end else if (act_u) begin
                    armed_next = ~alarm_armed;
                end
            end
            ADJ_CMIN: begin
                if (act_c)      state_next = CLOCK;
                else if (act_r) state_next = ADJ_CHR;
                else if (act_l) state_next = ADJ_AHR;
                else if (act_u | act_d) begin
                    min_stb_next = 1'b1;
                    up_next      = act_u;
                end
            end
            ADJ_CHR: begin
                if (act_c)      state_next = CLOCK;
                else if (act_r) state_next = ADJ_AMIN;
                else if (act_l) state_next = ADJ_CMIN;
                else if (act_u | act_d) begin
                    hr_stb_next = 1'b1;
                    up_next     = act_u;
                end
            end
            ADJ_AMIN: begin
                if (act_c)              state_next = CLOCK;
                else if (act_r)         state_next = ADJ_AHR;
                else if (act_l)         state_next = ADJ_CHR;
                else if (act_u | act_d) alarm_next = step_min(alarm_bcd, act_u);
            end
            ADJ_AHR: begin
                if (act_c)              state_next = CLOCK;
                else if (act_r)         state_next = ADJ_CMIN;
                else if (act_l)         state_next = ADJ_AMIN;
                else if (act_u | act_d) alarm_next = step_hr(alarm_bcd, act_u);
            end
            RING: begin
                if (any_btn) begin
                    state_next = CLOCK;
                end else if (tick_1hz) begin
                    if (ring_cnt == RING_LAST) begin
                        state_next = CLOCK;
                    end else begin
                        ring_cnt_next = ring_cnt + 8'd1;
                        blink_next    = ~led[4];
                    end
                end
            end
            default: state_next = CLOCK;
        endcase

        case (state_next)
            CLOCK:    run_en_next = 1'b1;
            ADJ_CMIN: led_next = 5'b00011;
            ADJ_CHR:  led_next = 5'b00101;
            ADJ_AMIN: begin
                led_next  = 5'b01011;
                disp_next = 1'b1;
            end
            ADJ_AHR: begin
                led_next  = 5'b01101;
                disp_next = 1'b1;
            end
            RING: begin
                run_en_next = 1'b1;
                led_next    = {blink_next, 4'b0000};
            end
            default: run_en_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= CLOCK;
            ring_cnt    <= 8'd0;
            match_q     <= 1'b0;
            alarm_bcd   <= 13'd0;
            alarm_armed <= 1'b0;
            adj_min_stb <= 1'b0;
            adj_hr_stb  <= 1'b0;
            adj_up      <= 1'b0;
            run_en      <= 1'b1;
            disp_alarm  <= 1'b0;
            ringing     <= 1'b0;
            led         <= 5'b00000;
        end else begin
            state       <= state_next;
            ring_cnt    <= ring_cnt_next;
            match_q     <= match;
            alarm_bcd   <= alarm_next;
            alarm_armed <= armed_next;
            adj_min_stb <= min_stb_next;
            adj_hr_stb  <= hr_stb_next;
            adj_up      <= up_next;
            run_en      <= run_en_next;
            disp_alarm  <= disp_next;
            ringing     <= (state_next == RING);
            led         <= led_next;
        end
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: a vector table for mode/adjust behaviour plus
// hand-written ring, match-discard and async-reset sequences.
module tb_clock_mode_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_c, btn_r, btn_l, btn_u, btn_d;
    logic        tick_1hz;
    logic [12:0] time_bcd;
    logic        run_en, adj_min_stb, adj_hr_stb, adj_up;
    logic [12:0] alarm_bcd;
    logic        disp_alarm, alarm_armed, ringing;
    logic [4:0]  led;

    clock_mode_ctrl #(.RING_SECS(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_c       (btn_c),
        .btn_r       (btn_r),
        .btn_l       (btn_l),
        .btn_u       (btn_u),
        .btn_d       (btn_d),
        .tick_1hz    (tick_1hz),
        .time_bcd    (time_bcd),
        .run_en      (run_en),
        .adj_min_stb (adj_min_stb),
        .adj_hr_stb  (adj_hr_stb),
        .adj_up      (adj_up),
        .alarm_bcd   (alarm_bcd),
        .disp_alarm  (disp_alarm),
        .alarm_armed (alarm_armed),
        .ringing     (ringing),
        .led         (led)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_C    = 5'b10000;
    localparam logic [4:0] B_R    = 5'b01000;
    localparam logic [4:0] B_L    = 5'b00100;
    localparam logic [4:0] B_U    = 5'b00010;
    localparam logic [4:0] B_D    = 5'b00001;

    typedef struct {
        logic [4:0]  btn;
        logic [24:0] want;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [24:0] actual;
    assign actual = {led, run_en, adj_min_stb, adj_hr_stb, adj_up,
                     disp_alarm, alarm_armed, ringing, alarm_bcd};

    function automatic logic [12:0] bcd(input int hh, input int mm);
        return {2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10)};
    endfunction

    function automatic logic [24:0] e(input logic [4:0] l, input logic run, input logic mstb,
                                      input logic hstb, input logic up, input logic disp,
                                      input logic armed, input logic ring, input logic [12:0] al);
        return {l, run, mstb, hstb, up, disp, armed, ring, al};
    endfunction

    task automatic checkOutput(input string name, input logic [24:0] want);
        total++;
        if (actual !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, want);
        end
    endtask

    task automatic checkBit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    // Inputs held for one clock edge, then released; outputs sampled 1 time unit later
    task automatic applyStimulus(input logic [4:0] b, input logic tk);
        {btn_c, btn_r, btn_l, btn_u, btn_d} = b;
        tick_1hz = tk;
        @(posedge clk);
        #1;
        {btn_c, btn_r, btn_l, btn_u, btn_d} = B_NONE;
        tick_1hz = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(B_NONE, 1'b0);
    endtask

    vec_t vecs [26];

    initial begin
        logic [12:0] a0, a59, a23;
        a0  = bcd(0, 0);
        a59 = bcd(0, 59);
        a23 = bcd(23, 0);

        vecs[0]  = '{B_C,             e(5'b00011, 0, 0, 0, 0, 0, 0, 0, a0)};
        vecs[1]  = '{B_U,             e(5'b00011, 0, 1, 0, 1, 0, 0, 0, a0)};
        vecs[2]  = '{B_NONE,          e(5'b00011, 0, 0, 0, 0, 0, 0, 0, a0)};
        vecs[3]  = '{B_R,             e(5'b00101, 0, 0, 0, 0, 0, 0, 0, a0)};
        vecs[4]  = '{B_D,             e(5'b00101, 0, 0, 1, 0, 0, 0, 0, a0)};
        vecs[5]  = '{B_NONE,          e(5'b00101, 0, 0, 0, 0, 0, 0, 0, a0)};
        vecs[6]  = '{B_R,             e(5'b01011, 0, 0, 0, 0, 1, 0, 0, a0)};
        vecs[7]  = '{B_D,             e(5'b01011, 0, 0, 0, 0, 1, 0, 0, a59)};
        vecs[8]  = '{B_U,             e(5'b01011, 0, 0, 0, 0, 1, 0, 0, a0)};
        vecs[9]  = '{B_R,             e(5'b01101, 0, 0, 0, 0, 1, 0, 0, a0)};
        vecs[10] = '{B_D,             e(5'b01101, 0, 0, 0, 0, 1, 0, 0, a23)};
        vecs[11] = '{B_U,             e(5'b01101, 0, 0, 0, 0, 1, 0, 0, a0)};
        vecs[12] = '{B_D,             e(5'b01101, 0, 0, 0, 0, 1, 0, 0, a23)};
        vecs[13] = '{B_L,             e(5'b01011, 0, 0, 0, 0, 1, 0, 0, a23)};
        vecs[14] = '{B_L,             e(5'b00101, 0, 0, 0, 0, 0, 0, 0, a23)};
        vecs[15] = '{B_L,             e(5'b00011, 0, 0, 0, 0, 0, 0, 0, a23)};
        vecs[16] = '{B_L,             e(5'b01101, 0, 0, 0, 0, 1, 0, 0, a23)};
        vecs[17] = '{B_C,             e(5'b00000, 1, 0, 0, 0, 0, 0, 0, a23)};
        vecs[18] = '{B_U,             e(5'b00000, 1, 0, 0, 0, 0, 1, 0, a23)};
        vecs[19] = '{B_C | B_U,       e(5'b00011, 0, 0, 0, 0, 0, 1, 0, a23)};
        vecs[20] = '{B_R | B_L | B_D, e(5'b00101, 0, 0, 0, 0, 0, 1, 0, a23)};
        vecs[21] = '{B_C,             e(5'b00000, 1, 0, 0, 0, 0, 1, 0, a23)};
        vecs[22] = '{B_U,             e(5'b00000, 1, 0, 0, 0, 0, 0, 0, a23)};
        vecs[23] = '{B_R,             e(5'b00000, 1, 0, 0, 0, 0, 0, 0, a23)};
        vecs[24] = '{B_D,             e(5'b00000, 1, 0, 0, 0, 0, 0, 0, a23)};
        vecs[25] = '{B_L,             e(5'b00000, 1, 0, 0, 0, 0, 0, 0, a23)};

        reset    = 1'b0;
        {btn_c, btn_r, btn_l, btn_u, btn_d} = B_NONE;
        tick_1hz = 1'b0;
        time_bcd = bcd(12, 34);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset state", e(5'b00000, 1, 0, 0, 0, 0, 0, 0, 13'd0));
        reset = 1'b1;
        idle(1);
        checkOutput("idle after reset", e(5'b00000, 1, 0, 0, 0, 0, 0, 0, 13'd0));

        for (int i = 0; i < 26; i++) begin
            applyStimulus(vecs[i].btn, 1'b0);
            checkOutput($sformatf("vector %0d", i), vecs[i].want);
        end

        // Program alarm 07:30 from 23:00 and arm it
        applyStimulus(B_C, 1'b0);
        applyStimulus(B_R, 1'b0);
        applyStimulus(B_R, 1'b0);
        repeat (30) applyStimulus(B_U, 1'b0);
        checkOutput("alarm minutes 30", e(5'b01011, 0, 0, 0, 0, 1, 0, 0, bcd(23, 30)));
        applyStimulus(B_R, 1'b0);
        repeat (8) applyStimulus(B_U, 1'b0);
        applyStimulus(B_C, 1'b0);
        applyStimulus(B_U, 1'b0);
        checkOutput("alarm 07:30 armed", e(5'b00000, 1, 0, 0, 0, 0, 1, 0, bcd(7, 30)));

        // Match rings next cycle, blink toggles per tick, button dismisses
        time_bcd = bcd(7, 30);
        idle(1);
        checkOutput("ring entry", e(5'b10000, 1, 0, 0, 0, 0, 1, 1, bcd(7, 30)));
        applyStimulus(B_NONE, 1'b1);
        checkOutput("blink after tick 1", e(5'b00000, 1, 0, 0, 0, 0, 1, 1, bcd(7, 30)));
        applyStimulus(B_NONE, 1'b1);
        checkOutput("blink after tick 2", e(5'b10000, 1, 0, 0, 0, 0, 1, 1, bcd(7, 30)));
        applyStimulus(B_R, 1'b0);
        checkOutput("dismiss by btn_r", e(5'b00000, 1, 0, 0, 0, 0, 1, 0, bcd(7, 30)));
        for (int i = 0; i < 5; i++) begin
            idle(1);
            checkBit($sformatf("no re-ring cycle %0d", i), ringing, 1'b0);
        end

        // Auto-dismiss after RING_SECS ticks
        time_bcd = bcd(7, 31);
        idle(2);
        time_bcd = bcd(7, 30);
        idle(1);
        checkBit("second ring entry", ringing, 1'b1);
        applyStimulus(B_NONE, 1'b1);
        checkOutput("auto tick 1", e(5'b00000, 1, 0, 0, 0, 0, 1, 1, bcd(7, 30)));
        idle(3);
        checkBit("still ringing without ticks", ringing, 1'b1);
        applyStimulus(B_NONE, 1'b1);
        checkOutput("auto tick 2", e(5'b10000, 1, 0, 0, 0, 0, 1, 1, bcd(7, 30)));
        applyStimulus(B_NONE, 1'b1);
        idle(2);
        checkOutput("auto dismiss after tick 3", e(5'b00000, 1, 0, 0, 0, 0, 1, 0, bcd(7, 30)));

        // A match that rises while adjusting is dropped
        time_bcd = bcd(12, 34);
        idle(1);
        applyStimulus(B_C, 1'b0);
        time_bcd = bcd(7, 30);
        idle(3);
        applyStimulus(B_C, 1'b0);
        idle(3);
        checkOutput("match during adjust discarded", e(5'b00000, 1, 0, 0, 0, 0, 1, 0, bcd(7, 30)));

        // Asynchronous reset in the middle of ringing
        time_bcd = bcd(12, 34);
        idle(1);
        time_bcd = bcd(7, 30);
        idle(1);
        checkBit("ring before reset", ringing, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkBit("async reset clears ringing", ringing, 1'b0);
        checkOutput("async reset state", e(5'b00000, 1, 0, 0, 0, 0, 0, 0, 13'd0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);
        checkOutput("after reset release", e(5'b00000, 1, 0, 0, 0, 0, 0, 0, 13'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
